// File: rtl/decode_execute_stage.sv
// Y86-64 decode stage: register file, operand forwarding and the E pipeline register.
// Writeback from W lands at the clock edge and is also forwarded combinationally.
module decode_execute_stage #(
    parameter int         WIDTH = 64,
    parameter logic [3:0] RNONE = 4'hF,
    parameter logic [3:0] RSP   = 4'h4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       D_stat,
    input  logic [3:0]       D_Ins_Code,
    input  logic [3:0]       D_Ins_fun,
    input  logic [3:0]       D_rA,
    input  logic [3:0]       D_rB,
    input  logic [WIDTH-1:0] D_Val_C,
    input  logic [WIDTH-1:0] D_Val_P,
    input  logic [3:0]       e_dstE,
    input  logic [WIDTH-1:0] e_Val_E,
    input  logic [3:0]       M_dstE,
    input  logic [3:0]       M_dstM,
    input  logic [WIDTH-1:0] M_Val_E,
    input  logic [WIDTH-1:0] m_Val_M,
    input  logic [3:0]       W_dstE,
    input  logic [3:0]       W_dstM,
    input  logic [WIDTH-1:0] W_Val_E,
    input  logic [WIDTH-1:0] W_Val_M,
    input  logic             E_toBubble,
    output logic [3:0]       d_srcA,
    output logic [3:0]       d_srcB,
    output logic [2:0]       E_stat,
    output logic [3:0]       E_Ins_Code,
    output logic [3:0]       E_Ins_fun,
    output logic [WIDTH-1:0] E_Val_C,
    output logic [WIDTH-1:0] E_Val_A,
    output logic [WIDTH-1:0] E_Val_B,
    output logic [3:0]       E_dstE,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB
);

    logic [WIDTH-1:0] rf [15];
    logic [3:0]       d_dstE;
    logic [3:0]       d_dstM;
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] d_valA;

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_Ins_Code)
            4'h2, 4'h4, 4'h6, 4'hA: d_srcA = D_rA;
            4'h9, 4'hB:             d_srcA = RSP;
            default: ;
        endcase
        case (D_Ins_Code)
            4'h4, 4'h5, 4'h6:       d_srcB = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: d_srcB = RSP;
            default: ;
        endcase
        case (D_Ins_Code)
            4'h2, 4'h3, 4'h6:       d_dstE = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: d_dstE = RSP;
            default: ;
        endcase
        case (D_Ins_Code)
            4'h5, 4'hB: d_dstM = D_rA;
            default: ;
        endcase
    end

    // Youngest in-flight producer wins; RNONE never matches.
    function automatic logic [WIDTH-1:0] fwd(input logic [3:0] src);
        logic [WIDTH-1:0] v;
        v = '0;
        if (src == RNONE)       v = '0;
        else if (src == e_dstE) v = e_Val_E;
        else if (src == M_dstM) v = m_Val_M;
        else if (src == M_dstE) v = M_Val_E;
        else if (src == W_dstM) v = W_Val_M;
        else if (src == W_dstE) v = W_Val_E;
        else                    v = rf[src];
        return v;
    endfunction

    always_comb begin
        fwd_a = fwd(d_srcA);
        fwd_b = fwd(d_srcB);
        if (D_Ins_Code == 4'h7 || D_Ins_Code == 4'h8)
            d_valA = D_Val_P;
        else
            d_valA = fwd_a;
    end

    // dstM is written last so it wins when both target the same register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++)
                rf[i] <= '0;
        end else begin
            if (W_dstE != RNONE)
                rf[W_dstE] <= W_Val_E;
            if (W_dstM != RNONE)
                rf[W_dstM] <= W_Val_M;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || E_toBubble) begin
            E_stat     <= 3'd0;
            E_Ins_Code <= 4'h1;
            E_Ins_fun  <= 4'h0;
            E_Val_C    <= '0;
            E_Val_A    <= '0;
            E_Val_B    <= '0;
            E_dstE     <= RNONE;
            E_dstM     <= RNONE;
            E_srcA     <= RNONE;
            E_srcB     <= RNONE;
        end else begin
            E_stat     <= D_stat;
            E_Ins_Code <= D_Ins_Code;
            E_Ins_fun  <= D_Ins_fun;
            E_Val_C    <= D_Val_C;
            E_Val_A    <= d_valA;
            E_Val_B    <= fwd_b;
            E_dstE     <= d_dstE;
            E_dstM     <= d_dstM;
            E_srcA     <= d_srcA;
            E_srcB     <= d_srcB;
        end
    end

endmodule

// File: doc/decode_execute_stage.md
Name: decode_execute_stage

Overview:
- Decode stage of the Y86-64 pipeline: consumes the D_ pipeline register outputs and owns the 15-entry architectural register file.
- Selects source and destination register IDs and reads operands with full data forwarding.
- Writes back results from the W stage.
- Latches all decoded values into the E pipeline register, which supports bubble insertion for hazard control.

Parameters:
- WIDTH, 64, datapath width of register values.
- RNONE, 4'hF, register ID meaning "no register".
- RSP, 4'h4, stack pointer register ID.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- D_stat  in  3  status from decode register (0 AOK, 1 HLT, 2 ADR, 3 INS)
- D_Ins_Code  in  4  icode
- D_Ins_fun  in  4  ifun
- D_rA, D_rB  in  4 each  register specifiers
- D_Val_C  in  64  signed constant
- D_Val_P  in  64  incremented PC
- e_dstE  in  4  execute destination after condition check
- e_Val_E  in  64  ALU result
- M_dstE, M_dstM  in  4 each  memory-stage destinations
- M_Val_E  in  64  memory-stage valE
- m_Val_M  in  64  memory read data
- W_dstE, W_dstM  in  4 each  writeback destinations
- W_Val_E, W_Val_M  in  64 each  writeback data
- E_toBubble  in  1  load a bubble into E next edge
- d_srcA, d_srcB  out  4 each  combinational source IDs (for hazard control)
- E_stat  out  3  latched status
- E_Ins_Code, E_Ins_fun  out  4 each
- E_Val_C, E_Val_A, E_Val_B  out  64 each
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each

Behaviour:
- Reset (rst_n=0 at posedge): all 15 registers <= 0. E register <= bubble: Ins_Code 1, Ins_fun 0, stat 0, Val_C/Val_A/Val_B 0, dst/src = RNONE. Reset has priority over E_toBubble and over writeback.
- srcA selection:
  - rA for icode 2, 4, 6, A
  - RSP for 9, B
  - else RNONE
- srcB selection:
  - rB for 4, 5, 6
  - RSP for 8, 9, A, B
  - else RNONE
- dstE selection:
  - rB for 2, 3, 6
  - RSP for 8, 9, A, B
  - else RNONE
- dstM selection:
  - rA for 5, B
  - else RNONE
- d_valA:
  - D_Val_P when icode 7 or 8.
  - Otherwise forwarded or register value of srcA.
- Forwarding priority, first match wins, applies to both operands:
  1. e_dstE → e_Val_E
  2. M_dstM → m_Val_M
  3. M_dstE → M_Val_E
  4. W_dstM → W_Val_M
  5. W_dstE → W_Val_E
  6. register file
- A src of RNONE never matches any destination and yields 0.
- Register file read is combinational; write is at posedge.
  - Write W_Val_E to W_dstE if it is not RNONE.
  - Write W_Val_M to W_dstM if it is not RNONE.
  - If W_dstE == W_dstM (e.g. popq %rsp), W_Val_M wins.
  - Same-cycle read of a register being written returns the new value, via W forwarding.
- E register update, one-cycle latency at posedge:
  - If E_toBubble=1: load bubble values (as reset), but writeback still occurs.
  - Otherwise capture D_stat, icode, ifun, Val_C, d_valA, d_valB, dstE, dstM, srcA, srcB.
  - E is never stalled.
- Unknown icode (>B): all IDs RNONE; stat is passed through unchanged (fetch has already flagged INS).
- No arithmetic performed; all values pass through at full 64 bits.

Test Plan:
- Reset: hold rst_n=0 one edge → E_Ins_Code=1, E_dstE=F, E_Val_A=0; read of any register via OPq returns 0.
- Writeback then read: W_dstE=3, W_Val_E=0x55 for one edge, then decode addq %rbx,%rcx (rA=3, rB=1) with no in-flight destinations → E_Val_A=0x55, E_srcA=3, E_dstE=1.
- Forward priority: D = OPq rA=2; e_dstE=2 (0x11), M_dstE=2 (0x22), W_dstE=2 (0x33) → E_Val_A=0x11. Drop e_dstE to F → 0x22. Drop M_dstE to F → 0x33.
- popq %rsp writeback conflict: W_dstE=4 (0x100), W_dstM=4 (0x7) → register 4 reads 0x7 on the next cycle.
- Call/push: icode 8, D_Val_P=0x40, rsp=0x200 → E_Val_A=0x40, E_Val_B=0x200, E_dstE=4, E_dstM=F. For pushq rA=1, d_srcA=1, d_srcB=4.
- Bubble with concurrent writeback: E_toBubble=1, W_dstM=6 (0x9) → E holds nop/RNONE values and register 6 reads 0x9 afterwards. Reset asserted in the same cycle → register 6 stays 0.
